db9md_pad_responder: RTL
========================

Name: db9md_pad_responder

Overview:
- Emulates a Sega Mega Drive 3/6-button pad on the DB9 user port. It is the responder end of the protocol that the DB9MD reader drives from the host side.
- Samples the external select line (TH), tracks the select-pulse sequence, and drives six active-low data lines from a joystick word in the DB9MD bit layout.
- Sits on the USER_IN/USER_OUT path when the core acts as a pad source, for example for link/test rigs or feeding another console.

Parameters:
- TIMEOUT_CYC, 60000, clk_sys cycles with no select edge before the sequence counter returns to 0 (1.5 ms at 40 MHz).
- SIX_BTN, 1, 1 = 6-button ID/extra-button phases enabled; 0 = plain 3-button pad.

Ports:
- clk_sys, in, 1, system clock (35-50 MHz).
- reset, in, 1, synchronous, active-high.
- en, in, 1, 1 = drive pad data; 0 = all lines released (6'h3F).
- sel_in, in, 1, asynchronous select/TH from the host.
- joy, in, 12, active-high buttons: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z.
- data_out, out, 6, active-low pad lines D0..D5 (registered).
- seq_phase, out, 3, current sequence count, for debug/verification.

Behaviour:
- Reset values:
  - data_out = 6'h3F; seq_phase/cnt = 0; timeout counter = 0.
  - Both sync flops = 1, so no spurious falling edge leaves reset.
- Synchronisation:
  - sel_in passes through 2 flops to give sel_s.
  - fall = previous sel_s 1 and current sel_s 0; edge = any change of sel_s.
- cnt (3 bits), updated in priority order:
  1. reset: cnt <= 0.
  2. fall: cnt <= (cnt == 5) ? 5 : cnt + 1. Saturating; the timeout check is ignored in the same cycle.
  3. timeout counter reaches TIMEOUT_CYC-1 with no edge: cnt <= 0.
- Timeout counter: cleared on any edge or reset, otherwise increments, saturating at TIMEOUT_CYC-1.
- When SIX_BTN = 0, cnt values 3 and 4 decode as the 3-button pattern for the current sel_s level.
- data_out bit order is {D5..D0}. Computed from sel_s, the updated cnt and joy, then registered:
  - sel_s=1, cnt != 3: {~C, ~B, ~R, ~L, ~D, ~U}.
  - sel_s=1, cnt == 3: {1, 1, ~Mode, ~X, ~Y, ~Z}.
  - sel_s=0, cnt in {0, 1, 2, 5}: {~Start, ~A, 0, 0, ~D, ~U}.
  - sel_s=0, cnt == 3: {~Start, ~A, 0, 0, 0, 0}. This is the 6-button ID.
  - sel_s=0, cnt == 4: {~Start, ~A, 1, 1, 1, 1}.
- en = 0: data_out <= 6'h3F next cycle. cnt and timeout still run, so the sequence stays coherent.
- Latency: a sel_in change is reflected on data_out exactly 3 clk_sys edges later (2 sync + 1 output register). A joy change is reflected 1 edge later.
- seq_phase = cnt (registered).
- Boundaries:
  - A sel glitch shorter than 1 clk may be missed; no requirement applies.
  - Reset mid-sequence returns to phase 0 the next cycle.
  - Timeout while sel is held low: cnt = 0 and the output follows the sel=0 row for cnt 0.

Test Plan:
1. Reset, en=1, sel_in=1, joy=12'h009 (R+U) -> data_out=6'h3F during reset; 3 clk after release it equals 6'b111110 & ~6'b001000 = 6'h36; seq_phase=0.
2. sel_in low, joy=12'h0C0 (A+Start) -> 3 clk after sel falls, data_out=6'b000011 (Start, A, D/U released with D3/D2=0); seq_phase=1.
3. Three low pulses 50 clk apart with joy=12'hE00 (X,Y,Z) and TIMEOUT_CYC=200:
   - third low -> data_out[3:0]=4'h0;
   - following high -> data_out=6'b111000;
   - fourth low -> data_out[3:0]=4'hF, seq_phase=4.
4. After step 3, hold sel_in=1 for TIMEOUT_CYC+5 clk -> seq_phase=0. The next low/high/low/high/low then reproduces the step 3 ID sequence from cnt 1.
5. SIX_BTN=0, same pulses as step 3 -> third low gives {~Start, ~A, 0, 0, ~D, ~U}; third high gives the normal {C, B, R, L, D, U} pattern; Z/Y/X never appear.
6. en=0 mid-sequence with any joy -> data_out=6'h3F next clk. Set en=1 at cnt=3 with sel high -> data_out shows the Z/Y/X/Mode pattern 1 clk later.

Source files
------------

// File: rtl/db9md_pad_responder_if.sv
// Pad-side signal bundle for the DB9 Mega Drive pad responder.
// No valid/ready handshake: sel_in is a free-running asynchronous level and data_out is a level.
interface db9md_pad_responder_if;
    logic        en;
    logic        sel_in;
    logic [11:0] joy;
    logic [5:0]  data_out;
    logic [2:0]  seq_phase;

    modport master (
        output en,
        output sel_in,
        output joy,
        input  data_out,
        input  seq_phase
    );

    modport slave (
        input  en,
        input  sel_in,
        input  joy,
        output data_out,
        output seq_phase
    );
endinterface

// File: rtl/db9md_pad_responder.sv
// Mega Drive 3/6-button pad emulator: tracks TH select pulses and drives
// the active-low D5..D0 lines from a DB9MD-layout joystick word.
module db9md_pad_responder #(
    parameter int TIMEOUT_CYC = 60000,
    parameter int SIX_BTN     = 1
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    db9md_pad_responder_if.slave        pad
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic SIX = (SIX_BTN != 0);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4,
        PH5 = 3'd5
    } phase_t;

    phase_t        phase, phase_next;
    logic          sync1, sel_s, sel_d;
    logic [TW-1:0] tcnt, tcnt_next;
    logic [5:0]    data_q, data_next;
    logic          fall, edge_any;
    logic          id_phase, ext_phase;

    assign fall     = sel_d & ~sel_s;
    assign edge_any = sel_d ^ sel_s;

    // Sync flops reset high so leaving reset never looks like a select fall.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1  <= 1'b1;
            sel_s  <= 1'b1;
            sel_d  <= 1'b1;
            phase  <= PH0;
            tcnt   <= '0;
            data_q <= 6'h3F;
        end else begin
            sync1  <= pad.sel_in;
            sel_s  <= sync1;
            sel_d  <= sel_s;
            phase  <= phase_next;
            tcnt   <= tcnt_next;
            data_q <= data_next;
        end
    end

    always_comb begin
        phase_next = phase;
        tcnt_next  = tcnt;
        data_next  = 6'h3F;
        id_phase   = 1'b0;
        ext_phase  = 1'b0;

        if (fall) begin
            phase_next = (phase == PH5) ? PH5 : phase_t'(phase + 3'd1);
        end else if (!edge_any && tcnt == T_MAX) begin
            phase_next = PH0;
        end

        if (edge_any) begin
            tcnt_next = '0;
        end else if (tcnt != T_MAX) begin
            tcnt_next = tcnt + 1'b1;
        end

        // Output decodes from the updated phase so it lands with seq_phase.
        id_phase  = SIX && (phase_next == PH3);
        ext_phase = SIX && (phase_next == PH4);

        if (sel_s) begin
            if (id_phase) begin
                data_next = {2'b11, ~pad.joy[8], ~pad.joy[9], ~pad.joy[10], ~pad.joy[11]};
            end else begin
                data_next = {~pad.joy[5], ~pad.joy[4], ~pad.joy[0],
                             ~pad.joy[1], ~pad.joy[2], ~pad.joy[3]};
            end
        end else begin
            if (id_phase) begin
                data_next = {~pad.joy[7], ~pad.joy[6], 4'b0000};
            end else if (ext_phase) begin
                data_next = {~pad.joy[7], ~pad.joy[6], 4'b1111};
            end else begin
                data_next = {~pad.joy[7], ~pad.joy[6], 2'b00, ~pad.joy[2], ~pad.joy[3]};
            end
        end

        if (!pad.en) begin
            data_next = 6'h3F;
        end
    end

    assign pad.data_out  = data_q;
    assign pad.seq_phase = phase;
endmodule
